// File: rtl/decoder_pkg.sv
// Shared constants and the active-low one-hot decode function for the
// registered 3-to-8 decoder.
package decoder_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 1 << SEL_W;
    localparam int IN_W  = SEL_W + 1;

    localparam logic [1:0]       ENA_ACTIVE = 2'b10;
    localparam logic [OUT_W-1:0] OUT_IDLE   = {OUT_W{1'b1}};

    // Enabled: only bit 'sel' is driven low. Disabled: every output idles high.
    function automatic logic [OUT_W-1:0] decode_onehot_n(
        input logic [SEL_W-1:0] sel,
        input logic             en
    );
        logic [OUT_W-1:0] vec;
        vec = OUT_IDLE;
        if (en) begin
            vec[sel] = 1'b0;
        end
        return vec;
    endfunction

endpackage

// File: rtl/decoder_3to8_comb.sv
// Pure combinational 74x138-style decoder: G1 high and G2 low enable one
// active-low output selected by sel.
module decoder_3to8_comb
    import decoder_pkg::*;
(
    input  logic [1:0]       ena,
    input  logic [SEL_W-1:0] sel,
    output logic             en,
    output logic [OUT_W-1:0] dec_n
);

    // Unknown enables compare as not-equal, so they fall to the idle pattern.
    assign en    = (ena == ENA_ACTIVE);
    assign dec_n = decode_onehot_n(sel, en);

endmodule

// File: rtl/decoder_3to8_reg.sv
// Registered 3-to-8 chip-select decoder with active-low outputs.
// Define DECODER_RANGE_ERR_EN to add the registered out-of-range flag oErr.
module decoder_3to8_reg
    import decoder_pkg::*;
#(
    parameter int RST_VAL_ALL1 = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [1:0]       iEna,
    input  logic [IN_W-1:0]  iData,
    output logic [OUT_W-1:0] oData
`ifdef DECODER_RANGE_ERR_EN
    ,
    output logic             oErr
`endif
);

    localparam logic [OUT_W-1:0] RST_VAL = (RST_VAL_ALL1 != 0) ? OUT_IDLE : '0;

    logic             en;
    logic [OUT_W-1:0] dec_n;

    decoder_3to8_comb u_comb (
        .ena   (iEna),
        .sel   (iData[SEL_W-1:0]),
        .en    (en),
        .dec_n (dec_n)
    );

    // NOTE: non-blocking assignment so the register samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oData <= RST_VAL;
        end else begin
            oData <= dec_n;
        end
    end

`ifdef DECODER_RANGE_ERR_EN
    // Out-of-range flag: the decode still follows the low select bits.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oErr <= 1'b0;
        end else begin
            oErr <= en & iData[SEL_W];
        end
    end
`else
    logic unused_sel_msb;
    assign unused_sel_msb = iData[SEL_W];
`endif

    // Chip selects must never overlap.
    a_one_select_max : assert property (
        @(posedge iClk) disable iff (iRst) $countones(~oData) <= 1
    );

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// Scoreboard bench for decoder_3to8_reg: stimulus pushes hand-computed
// expectations, a monitor pops and compares one per output sample.
module tb_decoder_3to8_reg;
    import decoder_pkg::*;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             e;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             iRst;
    logic [1:0]       iEna;
    logic [IN_W-1:0]  iData;
    logic [OUT_W-1:0] oData;
`ifdef DECODER_RANGE_ERR_EN
    logic             oErr;
`endif

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event mon_kick;

    always #5 clk = ~clk;

    decoder_3to8_reg dut (
        .iClk  (clk),
        .iRst  (iRst),
        .iEna  (iEna),
        .iData (iData),
        .oData (oData)
`ifdef DECODER_RANGE_ERR_EN
        ,
        .oErr  (oErr)
`endif
    );

    task automatic check(input exp_t x);
        logic act_e;
        act_e = 1'b0;
`ifdef DECODER_RANGE_ERR_EN
        act_e = oErr;
`endif
        n_cmp++;
        if (oData !== x.d || act_e !== x.e) begin
            n_bad++;
            $display("FAIL %s: got oData=%h oErr=%b, expected oData=%h oErr=%b",
                     x.name, oData, act_e, x.d, x.e);
        end
    endtask

    task automatic push(input logic [OUT_W-1:0] d, input logic e, input string name);
        exp_t x;
        x.d    = d;
        x.e    = e;
`ifndef DECODER_RANGE_ERR_EN
        x.e    = 1'b0;
`endif
        x.name = name;
        sb_q.push_back(x);
    endtask

    // Drive just after a falling edge; the result appears after the next rising edge.
    task automatic apply(input logic [1:0] ena, input logic [IN_W-1:0] data,
                         input logic [OUT_W-1:0] exp_d, input logic exp_e,
                         input string name);
        @(negedge clk);
        #1;
        iEna  = ena;
        iData = data;
        push(exp_d, exp_e, name);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk or mon_kick);
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                check(x);
            end
        end
    end

    initial begin : stimulus
        logic [OUT_W-1:0] sweep_exp [8];
        sweep_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        iRst  = 1'b0;
        iEna  = 2'b10;
        iData = 4'b0101;
        #1 iRst = 1'b1;
        #2;
        push(8'hFF, 1'b0, "reset_async_no_edge");
        ->mon_kick;

        @(negedge clk);
        #1 push(8'hFF, 1'b0, "reset_held_over_edge");
        @(negedge clk);
        #1 iRst = 1'b0;
        push(8'hDF, 1'b0, "reset_release");

        apply(2'b01, 4'd5, 8'hFF, 1'b0, "dis_01_d5");
        apply(2'b11, 4'd6, 8'hFF, 1'b0, "dis_11_d6");
        apply(2'b01, 4'd7, 8'hFF, 1'b0, "dis_01_d7");
        apply(2'b11, 4'd3, 8'hFF, 1'b0, "dis_11_d3");
        apply(2'bx1, 4'd5, 8'hFF, 1'b0, "dis_x1_d5");
        apply(2'b00, 4'd6, 8'hFF, 1'b0, "dis_00_d6");

        for (int k = 0; k < 8; k++)
            apply(2'b10, 4'(k), sweep_exp[k], 1'b0, $sformatf("sweep_%0d", k));

        apply(2'b10, 4'b1011, 8'hF7, 1'b1, "msb_set_d3");
        apply(2'b10, 4'b0011, 8'hF7, 1'b0, "msb_clr_d3");
        apply(2'b11, 4'b1011, 8'hFF, 1'b0, "msb_set_disabled");
        apply(2'b10, 4'b1111, 8'h7F, 1'b1, "msb_set_d7");

        apply(2'b10, 4'd2, 8'hFB, 1'b0, "trans_en_d2");
        apply(2'b01, 4'd2, 8'hFF, 1'b0, "trans_dis_d2");
        apply(2'b10, 4'd4, 8'hEF, 1'b0, "trans_en_and_data");
        apply(2'b11, 4'd1, 8'hFF, 1'b0, "trans_dis_and_data");
        apply(2'b10, 4'd1, 8'hFD, 1'b0, "trans_en_d1");

        apply(2'b10, 4'd7, 8'h7F, 1'b0, "pre_reset_7f");
        drain();
        @(posedge clk);
        #2 iRst = 1'b1;
        #1;
        push(8'hFF, 1'b0, "midrun_reset");
        ->mon_kick;
        #1 iRst = 1'b0;
        apply(2'b10, 4'd7, 8'h7F, 1'b0, "midrun_release");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
